commit_stage_np: RTL and testbench
==================================

# commit_stage_np

Parametrised N-port in-order commit stage. It retires up to NR_PORTS scoreboard heads per cycle into the GPR file and the store buffer. It owns the store-buffer credit counter, a fence sequencing FSM (drain, issue, wait for flush completion) and the retired-instruction counter. It sits between the issue-stage scoreboard and the register file, LSU, CSR file and controller.

## Interface
- NR_PORTS, 2, commit ports (1..4)
- XLEN, 64, data width
- ST_CREDITS, 4, store-buffer entries (1..15); credit counter width CW = $clog2(ST_CREDITS+1)
- CNT_W, 64, retire counter width
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-high
- halt_i  in  1  halt request; blocks all commits
- single_step_i  in  1  restrict commits to port 0
- instr_valid_i  in  NR_PORTS  scoreboard entry valid (port 0 is oldest)
- instr_ex_i  in  NR_PORTS  entry carries exception
- instr_kind_i  in  NR_PORTS×3  0 SIMPLE, 1 STORE, 2 CSR, 3 FENCE, 4 FENCE_I, 5 SFENCE_VMA; 6/7 treated as SIMPLE
- instr_rd_i  in  NR_PORTS×5  destination register
- instr_result_i  in  NR_PORTS×XLEN  result
- csr_rdata_i  in  XLEN  CSR read data
- csr_exception_i  in  1  CSR access faulted
- st_credit_return_i  in  1  store buffer freed one entry
- flush_done_i  in  1  controller finished the requested flush
- commit_ack_o  out  NR_PORTS  entry retired
- we_gpr_o / waddr_o / wdata_o  out  NR_PORTS / ×5 / ×XLEN  register-file write
- commit_lsu_o  out  NR_PORTS  store committed to store buffer
- commit_csr_o  out  1  CSR write commit
- fence_o, fence_i_o, sfence_vma_o  out  1 each  one-cycle flush request
- exception_valid_o  out  1  take exception of port 0
- no_st_pending_o  out  1  credits == ST_CREDITS
- retire_cnt_o  out  CNT_W  retired-instruction count

## Operation
- State FSM {IDLE, DRAIN, WAIT}, credit register avail[CW-1:0], retire_cnt register.
- Port 0 is eligible when instr_valid_i[0] is set, instr_ex_i[0] is clear, halt_i is low and state is IDLE (or DRAIN for the fence itself).
  - SIMPLE: ack and we_gpr.
  - STORE: ack and commit_lsu when avail ≥ 1, else stall.
  - CSR: commit_csr, wdata = csr_rdata_i, ack, unless csr_exception_i is set (then no ack, no we).
  - FENCE / FENCE_I / SFENCE_VMA: handled by the FSM.
- Port i>0 acks only when all of the following hold:
  - all lower ports acked;
  - port 0 kind is SIMPLE or STORE;
  - single_step_i is low;
  - instr_valid_i[i] is set and instr_ex_i[i] is clear;
  - kind is SIMPLE, or kind is STORE and avail ≥ the number of stores committed at ports 0..i.
- A failing port blocks all higher ports (in order).
- we_gpr_o[i] = commit_ack_o[i] and kind is not STORE. waddr_o = instr_rd_i. wdata_o = instr_result_i, except the port-0 CSR case.
- exception_valid_o = instr_valid_i[0] & !halt_i & (instr_ex_i[0] | (kind0 == CSR & csr_exception_i)).
- Credit update: avail_next = avail − popcount(commit_lsu_o) + st_credit_return_i.
  - A return while avail == ST_CREDITS with no store committed is ignored (saturate).
- Fence FSM:
  - IDLE with an eligible fence at port 0:
    - avail == ST_CREDITS: ack[0], pulse the matching fence output, go to WAIT.
    - otherwise: go to DRAIN, no ack.
  - DRAIN: when avail == ST_CREDITS and halt_i is low, ack[0], pulse, go to WAIT. halt_i in DRAIN returns to IDLE with no ack.
  - WAIT: no commits on any port. flush_done_i (sampled from the first cycle after the pulse) returns to IDLE. halt_i does not leave WAIT.
- retire_cnt_next = retire_cnt + popcount(commit_ack_o), modulo 2^CNT_W.

## Timing
- Reset values:
  - state = IDLE, avail = ST_CREDITS, retire_cnt = 0.
  - All pulse/ack/we outputs are 0 while instr_valid_i is 0.
  - no_st_pending_o = 1.
- Commit outputs are combinational from inputs plus registered state (0-cycle latency). Registers update on the clk_i rising edge.
- A fence with an empty store buffer acks in the same cycle.
- A fence with k stores outstanding acks in the cycle after avail reaches ST_CREDITS.
- retire_cnt_o reflects acks one cycle later.
- A returned credit is usable the cycle after st_credit_return_i.
- Asserting rst_i mid-DRAIN/WAIT forces IDLE immediately and discards any pending flush request.

## Test plan
- NR_PORTS=4, four valid SIMPLE entries rd=1..4 → ack=4'b1111, we_gpr=4'b1111; retire_cnt 0→4 next cycle.
- ST_CREDITS=2, avail=2, ports = STORE, STORE, STORE, SIMPLE → ack=4'b0011, commit_lsu=4'b0011; avail=0 next cycle; following cycle the head STORE stalls until st_credit_return_i.
- FENCE at port 0 with avail=2 of 4; two returns on cycles 1 and 2 → DRAIN; fence_o pulses exactly once on cycle 3 with ack[0]=1; ports stall in WAIT until flush_done_i, commits resume the next cycle.
- CSR at port 0 plus SIMPLE at port 1, csr_exception_i=0 → ack=2'b01, commit_csr_o=1, wdata_o[0]=csr_rdata_i. With csr_exception_i=1 → ack=0, exception_valid_o=1.
- Port 1 instr_ex_i=1 with SIMPLE ports 0 and 2 → ack=3'b001. single_step_i=1 with all SIMPLE → ack=1 on port 0 only. halt_i=1 → ack=0.
- rst_i asserted during WAIT → next cycle state IDLE, retire_cnt_o=0, no_st_pending_o=1.

Source files
------------

// File: rtl/commit_stage_np_if.sv
// Commit-stage bundle: scoreboard heads, CSR/LSU/controller handshakes, commit results.
// Purely combinational wiring, no latency of its own.
// Flow control is in-band: commit_ack_o retires a head, credits gate stores.
interface commit_stage_np_if #(
  parameter int NR_PORTS = 2,
  parameter int XLEN     = 64,
  parameter int CNT_W    = 64
);
  // scoreboard / control inputs to the commit stage
  logic                           halt_i;
  logic                           single_step_i;
  logic [NR_PORTS-1:0]            instr_valid_i;
  logic [NR_PORTS-1:0]            instr_ex_i;
  logic [NR_PORTS-1:0][2:0]       instr_kind_i;
  logic [NR_PORTS-1:0][4:0]       instr_rd_i;
  logic [NR_PORTS-1:0][XLEN-1:0]  instr_result_i;
  logic [XLEN-1:0]                csr_rdata_i;
  logic                           csr_exception_i;
  logic                           st_credit_return_i;
  logic                           flush_done_i;

  // commit results
  logic [NR_PORTS-1:0]            commit_ack_o;
  logic [NR_PORTS-1:0]            we_gpr_o;
  logic [NR_PORTS-1:0][4:0]       waddr_o;
  logic [NR_PORTS-1:0][XLEN-1:0]  wdata_o;
  logic [NR_PORTS-1:0]            commit_lsu_o;
  logic                           commit_csr_o;
  logic                           fence_o;
  logic                           fence_i_o;
  logic                           sfence_vma_o;
  logic                           exception_valid_o;
  logic                           no_st_pending_o;
  logic [CNT_W-1:0]               retire_cnt_o;

  // issue side: drives the heads, observes the commit results
  modport master (
    output halt_i, single_step_i, instr_valid_i, instr_ex_i, instr_kind_i,
           instr_rd_i, instr_result_i, csr_rdata_i, csr_exception_i,
           st_credit_return_i, flush_done_i,
    input  commit_ack_o, we_gpr_o, waddr_o, wdata_o, commit_lsu_o,
           commit_csr_o, fence_o, fence_i_o, sfence_vma_o,
           exception_valid_o, no_st_pending_o, retire_cnt_o
  );

  // commit stage itself
  modport slave (
    input  halt_i, single_step_i, instr_valid_i, instr_ex_i, instr_kind_i,
           instr_rd_i, instr_result_i, csr_rdata_i, csr_exception_i,
           st_credit_return_i, flush_done_i,
    output commit_ack_o, we_gpr_o, waddr_o, wdata_o, commit_lsu_o,
           commit_csr_o, fence_o, fence_i_o, sfence_vma_o,
           exception_valid_o, no_st_pending_o, retire_cnt_o
  );
endinterface

// File: rtl/commit_stage_np.sv
// In-order N-port commit: retires scoreboard heads into GPRs / store buffer, sequences fences.
// Latency: commit outputs are combinational (0 cycles); credit, FSM and retire count update next edge.
// Backpressure: stores stall without credits, a failing port blocks all younger ports, WAIT blocks everything.
module commit_stage_np #(
  parameter int NR_PORTS   = 2,
  parameter int XLEN       = 64,
  parameter int ST_CREDITS = 4,
  parameter int CNT_W      = 64
) (
  input  logic               clk_i,
  input  logic               rst_i,
  commit_stage_np_if.slave   cif
);

  localparam int CW = $clog2(ST_CREDITS + 1);
  localparam int PW = $clog2(NR_PORTS + 1);
  // common width for credit arithmetic so store counts and credits compare cleanly
  localparam int AW = ((CW > PW) ? CW : PW) + 1;

  localparam logic [CW-1:0] CREDITS_FULL = CW'(ST_CREDITS);

  localparam logic [2:0] K_SIMPLE  = 3'd0;
  localparam logic [2:0] K_STORE   = 3'd1;
  localparam logic [2:0] K_CSR     = 3'd2;
  localparam logic [2:0] K_FENCE   = 3'd3;
  localparam logic [2:0] K_FENCE_I = 3'd4;
  localparam logic [2:0] K_SFENCE  = 3'd5;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_DRAIN = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;

  // kinds 6 and 7 are reserved encodings and retire like plain ALU results
  function automatic logic is_simple(input logic [2:0] k);
    return (k == K_SIMPLE) || (k == 3'd6) || (k == 3'd7);
  endfunction

  function automatic logic is_fence(input logic [2:0] k);
    return (k == K_FENCE) || (k == K_FENCE_I) || (k == K_SFENCE);
  endfunction

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    avail_q, avail_d;
  logic [CNT_W-1:0] retire_cnt_q, retire_cnt_d;

  logic [NR_PORTS-1:0] ack;
  logic [NR_PORTS-1:0] lsu;
  logic                csr_commit;
  logic                fence_pulse;
  logic                fence_i_pulse;
  logic                sfence_pulse;
  logic                credits_full;
  logic                head_ok;
  logic [2:0]          kind0;

  assign credits_full = (avail_q == CREDITS_FULL);
  assign kind0        = cif.instr_kind_i[0];
  assign head_ok      = cif.instr_valid_i[0] & ~cif.instr_ex_i[0] & ~cif.halt_i;

  // commit decision: port 0 by kind and FSM state, younger ports chained in order behind it
  always_comb begin
    logic [AW-1:0] stores;
    ack           = '0;
    lsu           = '0;
    csr_commit    = 1'b0;
    fence_pulse   = 1'b0;
    fence_i_pulse = 1'b0;
    sfence_pulse  = 1'b0;
    stores        = '0;

    if (head_ok && (state_q == ST_IDLE)) begin
      if (is_simple(kind0)) begin
        ack[0] = 1'b1;
      end else if (kind0 == K_STORE) begin
        if (avail_q != '0) begin
          ack[0] = 1'b1;
          lsu[0] = 1'b1;
        end
      end else if (kind0 == K_CSR) begin
        if (!cif.csr_exception_i) begin
          ack[0]     = 1'b1;
          csr_commit = 1'b1;
        end
      end else begin
        // fence with an already empty store buffer retires right away
        ack[0] = credits_full;
      end
    end else if (head_ok && (state_q == ST_DRAIN) && is_fence(kind0) && credits_full) begin
      ack[0] = 1'b1;
    end

    if (ack[0] && is_fence(kind0)) begin
      fence_pulse   = (kind0 == K_FENCE);
      fence_i_pulse = (kind0 == K_FENCE_I);
      sfence_pulse  = (kind0 == K_SFENCE);
    end

    stores = AW'(lsu[0]);

    // younger ports only ride along behind a simple/store head and never in single-step
    for (int i = 1; i < NR_PORTS; i++) begin
      if (ack[i-1] && (is_simple(kind0) || (kind0 == K_STORE)) && !cif.single_step_i &&
          cif.instr_valid_i[i] && !cif.instr_ex_i[i]) begin
        if (is_simple(cif.instr_kind_i[i])) begin
          ack[i] = 1'b1;
        end else if ((cif.instr_kind_i[i] == K_STORE) &&
                     (AW'(avail_q) >= (stores + AW'(1)))) begin
          ack[i] = 1'b1;
          lsu[i] = 1'b1;
          stores = stores + AW'(1);
        end
      end
    end
  end

  // register-file write port and remaining outputs
  always_comb begin
    for (int i = 0; i < NR_PORTS; i++) begin
      cif.we_gpr_o[i] = ack[i] & (cif.instr_kind_i[i] != K_STORE);
      cif.waddr_o[i]  = cif.instr_rd_i[i];
      cif.wdata_o[i]  = cif.instr_result_i[i];
    end
    if (kind0 == K_CSR) begin
      cif.wdata_o[0] = cif.csr_rdata_i;
    end
    cif.commit_ack_o      = ack;
    cif.commit_lsu_o      = lsu;
    cif.commit_csr_o      = csr_commit;
    cif.fence_o           = fence_pulse;
    cif.fence_i_o         = fence_i_pulse;
    cif.sfence_vma_o      = sfence_pulse;
    cif.exception_valid_o = cif.instr_valid_i[0] & ~cif.halt_i &
                            (cif.instr_ex_i[0] | ((kind0 == K_CSR) & cif.csr_exception_i));
    cif.no_st_pending_o   = credits_full;
    cif.retire_cnt_o      = retire_cnt_q;
  end

  // next credit count and retire count
  always_comb begin
    logic [PW-1:0] nst;
    logic [PW-1:0] nack;
    logic [AW-1:0] avail_n;
    nst  = '0;
    nack = '0;
    for (int i = 0; i < NR_PORTS; i++) begin
      nst  = nst + PW'(lsu[i]);
      nack = nack + PW'(ack[i]);
    end
    avail_n = AW'(avail_q) - AW'(nst) + AW'(cif.st_credit_return_i);
    // a spurious return into a full buffer must not overflow the counter
    if (credits_full && (nst == '0)) begin
      avail_n = AW'(avail_q);
    end
    avail_d      = avail_n[CW-1:0];
    retire_cnt_d = retire_cnt_q + CNT_W'(nack);
  end

  // fence sequencing: drain the store buffer, pulse the flush, wait for the controller
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (head_ok && is_fence(kind0)) begin
          state_d = credits_full ? ST_WAIT : ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (cif.halt_i) begin
          state_d = ST_IDLE;
        end else if (!(cif.instr_valid_i[0] && !cif.instr_ex_i[0] && is_fence(kind0))) begin
          // head was squashed while draining; nothing left to sequence
          state_d = ST_IDLE;
        end else if (credits_full) begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cif.flush_done_i) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // state registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      avail_q      <= CREDITS_FULL;
      retire_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      avail_q      <= avail_d;
      retire_cnt_q <= retire_cnt_d;
    end
  end

endmodule

// File: tb/tb_commit_stage_np.sv
// Directed bench for commit_stage_np (4 ports, 4 store credits) with a queue scoreboard.
// Driver changes inputs #1 after posedge and pushes the expected outputs for that cycle.
// Monitor pops one entry per falling edge and compares.
module tb_commit_stage_np;

  localparam int NP = 4;
  localparam int XL = 64;
  localparam int CN = 64;

  localparam logic [2:0] K_SIMPLE  = 3'd0;
  localparam logic [2:0] K_STORE   = 3'd1;
  localparam logic [2:0] K_CSR     = 3'd2;
  localparam logic [2:0] K_FENCE   = 3'd3;
  localparam logic [2:0] K_FENCE_I = 3'd4;
  localparam logic [2:0] K_SFENCE  = 3'd5;

  // flag nibble: {commit_csr, fence, fence_i, sfence_vma}
  localparam logic [3:0] F_NONE = 4'b0000;
  localparam logic [3:0] F_CSR  = 4'b1000;
  localparam logic [3:0] F_FEN  = 4'b0100;
  localparam logic [3:0] F_FI   = 4'b0010;
  localparam logic [3:0] F_SFV  = 4'b0001;

  typedef struct {
    string       name;
    logic [17:0] vec;
    logic [63:0] rcnt;
    logic        chk_wd;
    logic [63:0] wd0;
  } exp_t;

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  exp_t sb[$];
  exp_t e;

  commit_stage_np_if #(.NR_PORTS(NP), .XLEN(XL), .CNT_W(CN)) cif ();

  commit_stage_np #(
    .NR_PORTS(NP), .XLEN(XL), .ST_CREDITS(4), .CNT_W(CN)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .cif   (cif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // monitor: one expected record per cycle, compared mid-cycle
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      logic [17:0] act;
      e = sb.pop_front();
      act = {cif.commit_ack_o, cif.we_gpr_o, cif.commit_lsu_o, cif.commit_csr_o,
             cif.fence_o, cif.fence_i_o, cif.sfence_vma_o, cif.exception_valid_o,
             cif.no_st_pending_o};
      checks++;
      if (act !== e.vec) begin
        failures++;
        $display("FAIL %s outputs {ack,we,lsu,csr,fen,fi,sfv,exc,nsp} got=%b want=%b",
                 e.name, act, e.vec);
      end
      checks++;
      if (cif.retire_cnt_o !== e.rcnt) begin
        failures++;
        $display("FAIL %s retire_cnt got=%0d want=%0d", e.name, cif.retire_cnt_o, e.rcnt);
      end
      if (e.chk_wd) begin
        checks++;
        if (cif.wdata_o[0] !== e.wd0) begin
          failures++;
          $display("FAIL %s wdata0 got=%h want=%h", e.name, cif.wdata_o[0], e.wd0);
        end
      end
    end
  end

  task automatic clr();
    cif.halt_i             = 1'b0;
    cif.single_step_i      = 1'b0;
    cif.instr_valid_i      = '0;
    cif.instr_ex_i         = '0;
    cif.instr_kind_i       = '0;
    cif.instr_rd_i         = '0;
    cif.instr_result_i     = '0;
    cif.csr_rdata_i        = '0;
    cif.csr_exception_i    = 1'b0;
    cif.st_credit_return_i = 1'b0;
    cif.flush_done_i       = 1'b0;
  endtask

  task automatic sp(input int i, input logic [2:0] k, input logic [4:0] rd, input logic [63:0] res);
    cif.instr_valid_i[i]  = 1'b1;
    cif.instr_ex_i[i]     = 1'b0;
    cif.instr_kind_i[i]   = k;
    cif.instr_rd_i[i]     = rd;
    cif.instr_result_i[i] = res;
  endtask

  // push expectation for the current input set, then advance one cycle
  task automatic chk(input string nm, input logic [3:0] ack, input logic [3:0] we,
                     input logic [3:0] lsu, input logic [3:0] fl, input logic exc,
                     input logic nsp, input logic [63:0] rc, input logic cw,
                     input logic [63:0] wd);
    exp_t x;
    x.name   = nm;
    x.vec    = {ack, we, lsu, fl, exc, nsp};
    x.rcnt   = rc;
    x.chk_wd = cw;
    x.wd0    = wd;
    sb.push_back(x);
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    clr();
    repeat (2) @(posedge clk);
    #1;
    chk("reset", 4'b0, 4'b0, 4'b0, F_NONE, 0, 1, 0, 0, 0);
    rst = 1'b0;

    // four simple heads retire together
    clr(); for (int i = 0; i < NP; i++) sp(i, K_SIMPLE, 5'(i + 1), 64'(8'h11 * (i + 1)));
    chk("simple4", 4'b1111, 4'b1111, 4'b0, F_NONE, 0, 1, 0, 1, 64'h11);
    clr();
    chk("cnt4", 4'b0, 4'b0, 4'b0, F_NONE, 0, 1, 4, 0, 0);

    // consume two credits so two remain
    clr(); sp(0, K_STORE, 0, 0); sp(1, K_STORE, 0, 0);
    chk("st_pre", 4'b0011, 4'b0, 4'b0011, F_NONE, 0, 1, 4, 0, 0);
    clr(); sp(0, K_STORE, 0, 0); sp(1, K_STORE, 0, 0); sp(2, K_STORE, 0, 0); sp(3, K_SIMPLE, 7, 1);
    chk("st3_two_credits", 4'b0011, 4'b0, 4'b0011, F_NONE, 0, 0, 6, 0, 0);
    clr(); sp(0, K_STORE, 0, 0); sp(1, K_SIMPLE, 7, 1);
    chk("st_stall", 4'b0, 4'b0, 4'b0, F_NONE, 0, 0, 8, 0, 0);
    cif.st_credit_return_i = 1'b1;
    chk("st_ret_same_cycle", 4'b0, 4'b0, 4'b0, F_NONE, 0, 0, 8, 0, 0);
    cif.st_credit_return_i = 1'b0;
    chk("st_ret_usable", 4'b0011, 4'b0010, 4'b0001, F_NONE, 0, 0, 8, 0, 0);

    // bring avail back to 2 of 4
    clr(); cif.st_credit_return_i = 1'b1;
    chk("ret_a", 4'b0, 4'b0, 4'b0, F_NONE, 0, 0, 10, 0, 0);
    chk("ret_b", 4'b0, 4'b0, 4'b0, F_NONE, 0, 0, 10, 0, 0);

    // fence with stores outstanding: drain, pulse once, wait for flush
    clr(); sp(0, K_FENCE, 0, 0); sp(1, K_SIMPLE, 3, 3);
    chk("fence_c0", 4'b0, 4'b0, 4'b0, F_NONE, 0, 0, 10, 0, 0);
    cif.st_credit_return_i = 1'b1;
    chk("fence_c1", 4'b0, 4'b0, 4'b0, F_NONE, 0, 0, 10, 0, 0);
    chk("fence_c2", 4'b0, 4'b0, 4'b0, F_NONE, 0, 0, 10, 0, 0);
    cif.st_credit_return_i = 1'b0;
    chk("fence_c3", 4'b0001, 4'b0001, 4'b0, F_FEN, 0, 1, 10, 0, 0);
    clr(); sp(0, K_SIMPLE, 1, 1); sp(1, K_SIMPLE, 2, 2);
    chk("wait_a", 4'b0, 4'b0, 4'b0, F_NONE, 0, 1, 11, 0, 0);
    cif.flush_done_i = 1'b1;
    chk("wait_done", 4'b0, 4'b0, 4'b0, F_NONE, 0, 1, 11, 0, 0);
    cif.flush_done_i = 1'b0;
    chk("resume", 4'b0011, 4'b0011, 4'b0, F_NONE, 0, 1, 11, 0, 0);

    // fence.i with empty buffer acks in the same cycle
    clr(); sp(0, K_FENCE_I, 0, 0); sp(1, K_SIMPLE, 2, 2);
    chk("fence_i_now", 4'b0001, 4'b0001, 4'b0, F_FI, 0, 1, 13, 0, 0);
    clr(); cif.flush_done_i = 1'b1;
    chk("fi_done", 4'b0, 4'b0, 4'b0, F_NONE, 0, 1, 14, 0, 0);

    // CSR head: commits alone with csr read data, or faults
    clr(); sp(0, K_CSR, 5, 64'hAAAA); sp(1, K_SIMPLE, 6, 6);
    cif.csr_rdata_i = 64'h1234;
    chk("csr_ok", 4'b0001, 4'b0001, 4'b0, F_CSR, 0, 1, 14, 1, 64'h1234);
    cif.csr_exception_i = 1'b1;
    chk("csr_exc", 4'b0, 4'b0, 4'b0, F_NONE, 1, 1, 15, 1, 64'h1234);

    // exceptions, single step, halt
    clr(); sp(0, K_SIMPLE, 1, 1); sp(1, K_SIMPLE, 2, 2); sp(2, K_SIMPLE, 3, 3);
    cif.instr_ex_i[1] = 1'b1;
    chk("ex_port1", 4'b0001, 4'b0001, 4'b0, F_NONE, 0, 1, 15, 0, 0);
    clr(); sp(0, K_SIMPLE, 1, 1); cif.instr_ex_i[0] = 1'b1;
    chk("ex_port0", 4'b0, 4'b0, 4'b0, F_NONE, 1, 1, 16, 0, 0);
    clr(); for (int i = 0; i < NP; i++) sp(i, K_SIMPLE, 5'(i + 1), 1);
    cif.single_step_i = 1'b1;
    chk("single_step", 4'b0001, 4'b0001, 4'b0, F_NONE, 0, 1, 16, 0, 0);
    cif.single_step_i = 1'b0; cif.halt_i = 1'b1;
    chk("halt", 4'b0, 4'b0, 4'b0, F_NONE, 0, 1, 17, 0, 0);

    // sfence.vma, then reset while waiting for the flush
    clr(); sp(0, K_SFENCE, 0, 0);
    chk("sfence_now", 4'b0001, 4'b0001, 4'b0, F_SFV, 0, 1, 17, 0, 0);
    clr(); sp(0, K_SIMPLE, 1, 1);
    chk("wait_pre_rst", 4'b0, 4'b0, 4'b0, F_NONE, 0, 1, 18, 0, 0);
    clr(); rst = 1'b1;
    chk("rst_in_wait", 4'b0, 4'b0, 4'b0, F_NONE, 0, 1, 0, 0, 0);
    rst = 1'b0; sp(0, K_SIMPLE, 1, 1); sp(1, K_SIMPLE, 2, 2);
    chk("post_rst_idle", 4'b0011, 4'b0011, 4'b0, F_NONE, 0, 1, 0, 0, 0);
    clr();
    chk("post_rst_cnt", 4'b0, 4'b0, 4'b0, F_NONE, 0, 1, 2, 0, 0);

    // halt while draining drops back to idle without an ack
    clr(); sp(0, K_STORE, 0, 0);
    chk("st_one", 4'b0001, 4'b0, 4'b0001, F_NONE, 0, 1, 2, 0, 0);
    clr(); sp(0, K_FENCE, 0, 0);
    chk("fence_drain", 4'b0, 4'b0, 4'b0, F_NONE, 0, 0, 3, 0, 0);
    cif.halt_i = 1'b1; cif.st_credit_return_i = 1'b1;
    chk("drain_halt", 4'b0, 4'b0, 4'b0, F_NONE, 0, 0, 3, 0, 0);
    cif.halt_i = 1'b0; cif.st_credit_return_i = 1'b0;
    chk("fence_after_halt", 4'b0001, 4'b0001, 4'b0, F_FEN, 0, 1, 3, 0, 0);
    clr(); cif.flush_done_i = 1'b1;
    chk("fence2_done", 4'b0, 4'b0, 4'b0, F_NONE, 0, 1, 4, 0, 0);

    // spurious return into a full buffer saturates
    clr(); cif.st_credit_return_i = 1'b1;
    chk("sat_ret", 4'b0, 4'b0, 4'b0, F_NONE, 0, 1, 4, 0, 0);
    clr(); sp(0, K_STORE, 0, 0);
    chk("sat_store", 4'b0001, 4'b0, 4'b0001, F_NONE, 0, 1, 4, 0, 0);
    clr();
    chk("sat_after", 4'b0, 4'b0, 4'b0, F_NONE, 0, 0, 5, 0, 0);

    repeat (2) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain left=%0d want=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
